// File: rtl/pong_pkg.sv
// Shared state encoding, playfield constants and packed-ball layout for the GuitarPong frame sequencer.
package pong_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef logic signed [11:0] coord_t;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BALL_SIZE    = 8;
    localparam int BALL_SPEED   = 2;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_STEP  = 4;
    localparam int PADDLE_L_X   = 16;
    localparam int PADDLE_R_X   = 616;
    localparam int WIN_SCORE    = 7;
    localparam int SERVE_FRAMES = 60;

    localparam int X_MSB   = 31;
    localparam int X_LSB   = 21;
    localparam int Y_MSB   = 20;
    localparam int Y_LSB   = 10;
    localparam int DXN_BIT = 9;
    localparam int DYN_BIT = 8;

    localparam logic [10:0] BALL_X_CTR   = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y_CTR   = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] PADDLE_Y_CTR = 11'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [10:0] PADDLE_Y_MAX = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] BALL_Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] L_BOUNCE_X   = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] R_BOUNCE_X   = 11'(PADDLE_R_X - BALL_SIZE);

    function automatic coord_t to_coord(input logic [10:0] v);
        return coord_t'({1'b0, v});
    endfunction
endpackage

// File: rtl/pong_paddle.sv
// One paddle: top-edge y register, stepped once per enabled frame and clamped to the playfield.
module pong_paddle
    import pong_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_step,
    input  logic        i_up,
    input  logic        i_down,
    output logic [10:0] o_y
);
    localparam logic [10:0] STEP = 11'(PADDLE_STEP);

    logic [10:0] r_y;
    logic [10:0] w_y_nxt;

    always_comb begin
        w_y_nxt = r_y;
        if (i_up && !i_down)
            w_y_nxt = (r_y > STEP) ? r_y - STEP : 11'd0;
        else if (i_down && !i_up)
            w_y_nxt = (r_y < PADDLE_Y_MAX - STEP) ? r_y + STEP : PADDLE_Y_MAX;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_y <= PADDLE_Y_CTR;
        else if (i_step)
            r_y <= w_y_nxt;
    end

    assign o_y = r_y;
endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame GuitarPong sequencer: paddles, ball motion, collisions, score and serve/play/over flow.
// Build option PONG_AI_PADDLE_EN makes the right paddle track the ball instead of its buttons.
module pong_game_ctrl
    import pong_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pL_moveup,
    input  logic        pL_movedown,
    input  logic        pR_moveup,
    input  logic        pR_movedown,
    output logic [31:0] ball,
    output logic [10:0] pL_y,
    output logic [10:0] pR_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over,
    output logic [1:0]  state
);
    localparam logic [5:0] SERVE_CNT = 6'(SERVE_FRAMES);
    localparam logic [3:0] WIN_CNT   = 4'(WIN_SCORE);
    localparam coord_t     SPEED     = coord_t'(BALL_SPEED);

    state_t      r_state;
    logic [10:0] r_x, r_y;
    logic        r_dxn, r_dyn;
    logic [3:0]  r_score_l, r_score_r;
    logic        r_game_over;
    logic [5:0]  r_cnt;

    logic [10:0] w_pl_y, w_pr_y;
    logic        w_pad_step, w_pr_up, w_pr_down;

    assign w_pad_step = frame_tick && (r_state != ST_OVER);

    pong_paddle u_paddle_l (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_step (w_pad_step),
        .i_up   (pL_moveup),
        .i_down (pL_movedown),
        .o_y    (w_pl_y)
    );

    pong_paddle u_paddle_r (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_step (w_pad_step),
        .i_up   (w_pr_up),
        .i_down (w_pr_down),
        .o_y    (w_pr_y)
    );

    coord_t w_xs, w_ys, w_pl_s, w_pr_s, w_nx, w_ny;
    assign w_xs   = to_coord(r_x);
    assign w_ys   = to_coord(r_y);
    assign w_pl_s = to_coord(w_pl_y);
    assign w_pr_s = to_coord(w_pr_y);
    assign w_nx   = w_xs + (r_dxn ? -SPEED : SPEED);
    assign w_ny   = w_ys + (r_dyn ? -SPEED : SPEED);

`ifdef PONG_AI_PADDLE_EN
    // Centre-to-centre error; positive means the paddle sits below the ball.
    coord_t w_ai_err;
    assign w_ai_err  = (w_pr_s + coord_t'(PADDLE_H / 2)) - (w_ys + coord_t'(BALL_SIZE / 2));
    assign w_pr_up   = (w_ai_err >= coord_t'(PADDLE_STEP));
    assign w_pr_down = (w_ai_err <= -coord_t'(PADDLE_STEP));
`else
    assign w_pr_up   = pR_moveup;
    assign w_pr_down = pR_movedown;
`endif

    logic [10:0] w_y_nxt;
    logic        w_dyn_nxt;
    always_comb begin
        w_y_nxt   = w_ny[10:0];
        w_dyn_nxt = r_dyn;
        if (w_ny <= 12'sd0) begin
            w_y_nxt   = 11'd0;
            w_dyn_nxt = 1'b0;
        end else if (w_ny >= to_coord(BALL_Y_MAX)) begin
            w_y_nxt   = BALL_Y_MAX;
            w_dyn_nxt = 1'b1;
        end
    end

    // Paddle overlap is judged against pre-tick ball and paddle positions.
    logic w_ovl_l, w_ovl_r, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
    assign w_ovl_l  = (w_ys + coord_t'(BALL_SIZE) > w_pl_s) && (w_ys < w_pl_s + coord_t'(PADDLE_H));
    assign w_ovl_r  = (w_ys + coord_t'(BALL_SIZE) > w_pr_s) && (w_ys < w_pr_s + coord_t'(PADDLE_H));
    assign w_hit_l  = r_dxn && (w_nx <= to_coord(L_BOUNCE_X)) && (w_xs >= coord_t'(PADDLE_L_X)) && w_ovl_l;
    assign w_hit_r  = !r_dxn && (w_nx >= to_coord(R_BOUNCE_X))
                      && (w_xs <= coord_t'(PADDLE_R_X + PADDLE_W - BALL_SIZE)) && w_ovl_r;
    assign w_miss_l = (w_nx <= 12'sd0);
    assign w_miss_r = (w_nx >= coord_t'(SCREEN_W - BALL_SIZE));

    logic [3:0] w_score_l_inc, w_score_r_inc;
    logic       w_win;
    assign w_score_l_inc = r_score_l + 4'd1;
    assign w_score_r_inc = r_score_r + 4'd1;
    assign w_win = w_miss_l ? (w_score_r_inc == WIN_CNT) : (w_score_l_inc == WIN_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_x         <= BALL_X_CTR;
            r_y         <= BALL_Y_CTR;
            r_dxn       <= 1'b0;
            r_dyn       <= 1'b0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_game_over <= 1'b0;
            r_cnt       <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= SERVE_CNT;
                        r_state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (r_cnt <= 6'd1) begin
                            r_cnt   <= 6'd0;
                            r_state <= ST_PLAY;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        r_y   <= w_y_nxt;
                        r_dyn <= w_dyn_nxt;
                        if (w_hit_l) begin
                            r_x   <= L_BOUNCE_X;
                            r_dxn <= 1'b0;
                        end else if (w_hit_r) begin
                            r_x   <= R_BOUNCE_X;
                            r_dxn <= 1'b1;
                        end else if (w_miss_l || w_miss_r) begin
                            // Next serve heads toward the side that conceded; dy carries over.
                            r_x   <= BALL_X_CTR;
                            r_y   <= BALL_Y_CTR;
                            r_dyn <= r_dyn;
                            r_dxn <= w_miss_l;
                            if (w_miss_l)
                                r_score_r <= w_score_r_inc;
                            else
                                r_score_l <= w_score_l_inc;
                            if (w_win) begin
                                r_state     <= ST_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_cnt   <= SERVE_CNT;
                                r_state <= ST_SERVE;
                            end
                        end else begin
                            r_x <= w_nx[10:0];
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        r_score_l   <= 4'd0;
                        r_score_r   <= 4'd0;
                        r_x         <= BALL_X_CTR;
                        r_y         <= BALL_Y_CTR;
                        r_cnt       <= SERVE_CNT;
                        r_game_over <= 1'b0;
                        r_state     <= ST_SERVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ball                = 32'd0;
        ball[X_MSB:X_LSB]   = r_x;
        ball[Y_MSB:Y_LSB]   = r_y;
        ball[DXN_BIT]       = r_dxn;
        ball[DYN_BIT]       = r_dyn;
    end

    assign pL_y      = w_pl_y;
    assign pR_y      = w_pr_y;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign game_over = r_game_over;
    assign state     = r_state;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl against a frame-level behavioural model of the game rules.
module tb_pong_game_ctrl;
    logic        clock = 1'b0;
    logic        reset, frame_tick, start;
    logic        pL_moveup, pL_movedown, pR_moveup, pR_movedown;
    logic [31:0] ball;
    logic [10:0] pL_y, pR_y;
    logic [3:0]  score_l, score_r;
    logic        game_over;
    logic [1:0]  state;

    always #5 clock = ~clock;

    pong_game_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start       (start),
        .pL_moveup   (pL_moveup),
        .pL_movedown (pL_movedown),
        .pR_moveup   (pR_moveup),
        .pR_movedown (pR_movedown),
        .ball        (ball),
        .pL_y        (pL_y),
        .pR_y        (pR_y),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_over   (game_over),
        .state       (state)
    );

    int checks = 0;
    int failures = 0;

    // Model: positions in pixels, velocities as signed pixel steps, state 0..3.
    int m_st, m_cnt, m_x, m_y, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_x = 316; m_y = 236; m_dx = 2; m_dy = 2;
        m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0;
    endtask

    function automatic int pad_move(input int p, input bit up, input bit dn);
        int n;
        n = p;
        if (up && !dn) n = p - 4;
        if (dn && !up) n = p + 4;
        if (n < 0) n = 0;
        if (n > 416) n = 416;
        return n;
    endfunction

    function automatic bit overlaps(input int by, input int py);
        return (by + 8 > py) && (by < py + 64);
    endfunction

    task automatic model_score(input bit right_scores);
        m_x = 316; m_y = 236;
        if (right_scores) begin m_sr++; m_dx = -2; end
        else begin m_sl++; m_dx = 2; end
        if (m_sl == 7 || m_sr == 7) m_st = 3;
        else begin m_st = 1; m_cnt = 60; end
    endtask

    task automatic model_step(input bit tk, input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
        int nx, ny, ndy, opl, opr, err;
        bit aru, ard;
        aru = ru; ard = rd; err = 0;
`ifdef PONG_AI_PADDLE_EN
        err = (m_pr + 32) - (m_y + 4);
        aru = (err >= 4);
        ard = (err <= -4);
`endif
        opl = m_pl; opr = m_pr;
        if (tk && m_st != 3) begin
            m_pl = pad_move(m_pl, lu, ld);
            m_pr = pad_move(m_pr, aru, ard);
        end
        case (m_st)
            0: if (st) begin m_st = 1; m_cnt = 60; end
            1: if (tk) begin m_cnt--; if (m_cnt == 0) m_st = 2; end
            2: if (tk) begin
                nx = m_x + m_dx; ny = m_y + m_dy; ndy = m_dy;
                if (ny <= 0) begin ny = 0; ndy = 2; end
                else if (ny >= 472) begin ny = 472; ndy = -2; end
                if (m_dx < 0 && nx <= 24 && m_x >= 16 && overlaps(m_y, opl)) begin
                    m_x = 24; m_dx = 2; m_y = ny; m_dy = ndy;
                end else if (m_dx > 0 && nx + 8 >= 616 && m_x + 8 <= 624 && overlaps(m_y, opr)) begin
                    m_x = 608; m_dx = -2; m_y = ny; m_dy = ndy;
                end else if (nx <= 0) model_score(1'b1);
                else if (nx >= 632) model_score(1'b0);
                else begin m_x = nx; m_y = ny; m_dy = ndy; end
            end
            default: if (st) begin
                m_sl = 0; m_sr = 0; m_x = 316; m_y = 236; m_st = 1; m_cnt = 60;
            end
        endcase
    endtask

    function automatic logic [64:0] exp_vec();
        return {11'(m_x), 11'(m_y), (m_dx < 0), (m_dy < 0), 8'h00,
                11'(m_pl), 11'(m_pr), 4'(m_sl), 4'(m_sr), (m_st == 3), 2'(m_st)};
    endfunction

    function automatic logic [64:0] obs_vec();
        return {ball, pL_y, pR_y, score_l, score_r, game_over, state};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // {up, down} request: track follows the ball centre, otherwise runs to the far half.
    function automatic logic [1:0] steer(input int p, input bit track);
        int c, b;
        c = p + 32; b = m_y + 4;
        if (track) return {c > b + 2, c < b - 2};
        return (b < 240) ? 2'b01 : 2'b10;
    endfunction

    task automatic apply(input bit tk, input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
        frame_tick = tk; start = st;
        pL_moveup = lu; pL_movedown = ld; pR_moveup = ru; pR_movedown = rd;
        @(posedge clock); #1;
        model_step(tk, st, lu, ld, ru, rd);
        frame_tick = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; frame_tick = 1'b1; start = 1'b1; pL_moveup = 1'b1; pR_movedown = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; frame_tick = 1'b0; start = 1'b0; pL_moveup = 1'b0; pR_movedown = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ball !== 32'h2783B000) begin failures++; $display("FAIL reset_ball got=%h exp=%h", ball, 32'h2783B000); end
        checks++; if (pL_y !== 11'd208) begin failures++; $display("FAIL reset_pL_y got=%0d exp=208", pL_y); end
        checks++; if (pR_y !== 11'd208) begin failures++; $display("FAIL reset_pR_y got=%0d exp=208", pR_y); end
        checks++; if ({score_l, score_r} !== 8'h00) begin failures++; $display("FAIL reset_scores got=%h exp=00", {score_l, score_r}); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    endtask

    task automatic test_idle_paddles();
        for (int i = 0; i < 40; i++) begin
            apply(rb(), 1'b0, rb(), rb(), rb(), rb());
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL idle_paddles step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
    endtask

    task automatic test_paddle_clamp();
        int e;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, rb(), rb());
            e = 208 - 4 * k; if (e < 0) e = 0;
            checks++; if (pL_y !== 11'(e)) begin failures++; $display("FAIL clamp_up tick=%0d got=%0d exp=%0d", k, pL_y, e); end
        end
        for (int k = 1; k <= 5; k++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b1, rb(), rb());
            checks++; if (pL_y !== 11'd0) begin failures++; $display("FAIL clamp_both tick=%0d got=%0d exp=0", k, pL_y); end
        end
        for (int k = 1; k <= 110; k++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, rb(), rb());
            e = 4 * k; if (e > 416) e = 416;
            checks++; if (pL_y !== 11'(e)) begin failures++; $display("FAIL clamp_down tick=%0d got=%0d exp=%0d", k, pL_y, e); end
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL clamp_all got=%h exp=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_serve();
        logic [21:0] ctr, first;
        ctr = {11'd316, 11'd236};
        first = {11'd318, 11'd238};
        do_reset();
        apply(1'b0, 1'b1, rb(), rb(), rb(), rb());
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL serve_enter got=%0d exp=1", state); end
        for (int k = 1; k <= 60; k++) begin
            apply(1'b1, rb(), rb(), rb(), rb(), rb());
            checks++;
            if (state !== ((k < 60) ? 2'd1 : 2'd2) || ball[31:10] !== ctr) begin
                failures++; $display("FAIL serve_hold tick=%0d state=%0d ball=%h", k, state, ball);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL serve_model tick=%0d got=%h exp=%h", k, obs_vec(), exp_vec()); end
        end
        apply(1'b1, 1'b0, rb(), rb(), rb(), rb());
        checks++; if (ball[31:10] !== first) begin failures++; $display("FAIL serve_first_step got=%h exp=%h", ball[31:10], first); end
    endtask

    task automatic test_right_scores();
        logic [1:0]  sl, sr;
        logic [21:0] ctr;
        ctr = {11'd316, 11'd236};
        for (int i = 0; i < 4000 && m_sr == 0; i++) begin
            sl = steer(m_pl, 1'b0); sr = steer(m_pr, 1'b1);
            apply(1'b1, 1'b0, sl[1], sl[0], sr[1], sr[0]);
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL rally_r step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
        checks++; if (m_sr != 1) begin failures++; $display("FAIL right_score_timeout got=%0d exp=1", m_sr); end
        checks++; if (score_r !== 4'd1 || state !== 2'd1) begin failures++; $display("FAIL right_score score_r=%0d state=%0d exp 1/1", score_r, state); end
        checks++; if (ball[31:10] !== ctr || ball[9] !== 1'b1) begin failures++; $display("FAIL right_score_ball got=%h", ball); end
    endtask

    task automatic test_random_play();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 560; i++) begin
            if (rb()) apply(1'b0, rb(), rb(), rb(), rb(), rb());
            apply(1'b1, rb(), rb(), rb(), rb(), rb());
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL random_play step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
    endtask

    task automatic test_game_over();
        logic [1:0]  sl, sr;
        logic [64:0] frozen;
        logic [21:0] ctr;
        ctr = {11'd316, 11'd236};
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12000 && m_st != 3; i++) begin
            sl = steer(m_pl, 1'b1); sr = steer(m_pr, 1'b0);
            apply(1'b1, 1'b0, sl[1], sl[0], sr[1], sr[0]);
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL rally_l step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
        checks++; if (m_st != 3) begin failures++; $display("FAIL game_over_timeout got=%0d exp=3", m_st); end
        checks++;
        if (score_l !== 4'd7 || game_over !== 1'b1 || state !== 2'd3) begin
            failures++; $display("FAIL game_over score_l=%0d go=%b state=%0d exp 7/1/3", score_l, game_over, state);
        end
        frozen = exp_vec();
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 1'b0, rb(), rb(), rb(), rb());
            checks++;
            if (obs_vec() !== frozen) begin failures++; $display("FAIL over_frozen tick=%0d got=%h exp=%h", k, obs_vec(), frozen); end
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({score_l, score_r} !== 8'h00 || state !== 2'd1 || game_over !== 1'b0 || ball[31:10] !== ctr) begin
            failures++; $display("FAIL restart scores=%h state=%0d go=%b ball=%h", {score_l, score_r}, state, game_over, ball);
        end
    endtask

    task automatic test_reset_mid_play();
        logic [64:0] rv;
        rv = {32'h2783B000, 11'd208, 11'd208, 4'd0, 4'd0, 1'b0, 2'd0};
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) apply(1'b1, 1'b0, rb(), rb(), rb(), rb());
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL mid_play_setup got=%0d exp=2", state); end
        reset = 1'b1;
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        model_reset();
        checks++; if (obs_vec() !== rv) begin failures++; $display("FAIL reset_mid_play got=%h exp=%h", obs_vec(), rv); end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        pL_moveup = 1'b0; pL_movedown = 1'b0; pR_moveup = 1'b0; pR_movedown = 1'b0;
        model_reset();
        test_reset();
        test_idle_paddles();
        test_paddle_clamp();
        test_serve();
        test_right_scores();
        test_random_play();
`ifndef PONG_AI_PADDLE_EN
        test_game_over();
`endif
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end
endmodule
